// File: rtl/l2_pkg.sv
// -----------------------------------------------------------------------------
// l2_pkg
// Shared definitions for the unified L2 cache: bus widths, default geometry
// and the controller state encoding.
// No ports (package).
// -----------------------------------------------------------------------------
package l2_pkg;

    localparam int LINE_W         = 128;  // one cache line, also one bus beat
    localparam int ADDR_W         = 28;   // line-granular address
    localparam int L2_NUM_OF_SET  = 64;   // default number of lines
    localparam int L2_SET_OFFSET  = 6;    // default log2(number of lines)

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_COMPARE   = 3'd1,
        ST_WRITEBACK = 3'd2,
        ST_ALLOCATE  = 3'd3,
        ST_RESPOND   = 3'd4
    } l2_state_e;

endpackage

// File: rtl/l2_cache_if.sv
// -----------------------------------------------------------------------------
// l2_cache_if
// Line-granular request/response bus seen by the L2 cache: the upstream
// (L1-facing) port and the downstream (memory-facing) port.
//
// Handshake: a requester raises read or write (never both for a real request)
// together with address/data and holds all of them until the responder pulses
// ready for exactly one cycle. The response data is meaningful only in the
// ready cycle. The requester drops its request after seeing ready.
//
// Modports:
//   slave  - the cache view: L1 requests in, L1 responses out,
//            memory requests out, memory responses in.
//   master - the environment view (L1 + main memory), the mirror image.
// -----------------------------------------------------------------------------
interface l2_cache_if;
    import l2_pkg::*;

    // upstream (L1) side
    logic              l1_read;
    logic              l1_write;
    logic [ADDR_W-1:0] l1_addr;
    logic [LINE_W-1:0] l1_wdata;
    logic [LINE_W-1:0] l1_rdata;
    logic              l1_ready;

    // downstream (memory) side
    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [LINE_W-1:0] mem_wdata;
    logic [LINE_W-1:0] mem_rdata;
    logic              mem_ready;

    modport slave (
        input  l1_read, l1_write, l1_addr, l1_wdata,
        output l1_rdata, l1_ready,
        output mem_read, mem_write, mem_addr, mem_wdata,
        input  mem_rdata, mem_ready
    );

    modport master (
        output l1_read, l1_write, l1_addr, l1_wdata,
        input  l1_rdata, l1_ready,
        input  mem_read, mem_write, mem_addr, mem_wdata,
        output mem_rdata, mem_ready
    );

endinterface

// File: rtl/l2_tag_ram.sv
// -----------------------------------------------------------------------------
// l2_tag_ram
// Per-set valid / dirty / tag storage for the direct-mapped L2.
// Valid and dirty bits clear asynchronously on reset; tags are not reset
// because they are only looked at when the valid bit is set.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   i_rd_idx              set index to look up (combinational read)
//   o_rd_valid/dirty/tag  contents of that set
//   i_we                  write strobe
//   i_wr_idx              set index to write
//   i_wr_valid/dirty/tag  new contents
// -----------------------------------------------------------------------------
module l2_tag_ram #(
    parameter int NUM_OF_SET = 64,
    parameter int SET_OFFSET = 6,
    parameter int TAG_W      = 22
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [SET_OFFSET-1:0] i_rd_idx,
    output logic                  o_rd_valid,
    output logic                  o_rd_dirty,
    output logic [TAG_W-1:0]      o_rd_tag,
    input  logic                  i_we,
    input  logic [SET_OFFSET-1:0] i_wr_idx,
    input  logic                  i_wr_valid,
    input  logic                  i_wr_dirty,
    input  logic [TAG_W-1:0]      i_wr_tag
);

    logic [NUM_OF_SET-1:0] r_valid;
    logic [NUM_OF_SET-1:0] r_dirty;
    logic [TAG_W-1:0]      r_tag [NUM_OF_SET];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
            r_dirty <= '0;
        end else if (i_we) begin
            r_valid[i_wr_idx] <= i_wr_valid;
            r_dirty[i_wr_idx] <= i_wr_dirty;
        end
    end

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_tag[i_wr_idx] <= i_wr_tag;
        end
    end

    assign o_rd_valid = r_valid[i_rd_idx];
    assign o_rd_dirty = r_dirty[i_rd_idx];
    assign o_rd_tag   = r_tag[i_rd_idx];

endmodule

// File: rtl/l2_cache.sv
// -----------------------------------------------------------------------------
// l2_cache
// Unified direct-mapped, write-back second-level cache with 128-bit lines.
// Sits between the L1 line interface and main memory; both sides use the
// same hold-until-ready line protocol (see l2_cache_if).
//
// Ports:
//   clk            clock, all state on the rising edge
//   proc_reset_n   asynchronous active-low reset
//   bus            l2_cache_if.slave (L1 side + memory side)
//   o_dbg_state    current controller state
//   perf_access    (only with L2_PERF_CNT_EN) lookups performed, wraps
//   perf_miss      (only with L2_PERF_CNT_EN) lookups that missed, wraps
//
// Optional feature macro: L2_PERF_CNT_EN adds the two performance counters.
// Without it the counters and their ports are absent.
//
// Flow: IDLE latches a request, COMPARE looks the line up, WRITEBACK evicts
// a dirty victim, ALLOCATE fetches a line for a read miss, RESPOND pulses
// l1_ready. Full-line writes never fetch from memory.
// -----------------------------------------------------------------------------
module l2_cache
    import l2_pkg::*;
#(
    parameter int NUM_OF_SET = L2_NUM_OF_SET,
    parameter int SET_OFFSET = L2_SET_OFFSET
) (
    input  logic       clk,
    input  logic       proc_reset_n,
    l2_cache_if.slave  bus,
    output l2_state_e  o_dbg_state
`ifdef L2_PERF_CNT_EN
    ,
    output logic [31:0] perf_access,
    output logic [31:0] perf_miss
`endif
);

    localparam int TAG_W = ADDR_W - SET_OFFSET;

    // request registers
    l2_state_e         r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [LINE_W-1:0] r_wdata;
    logic              r_is_wr;

    // registered outputs
    logic              r_l1_ready;
    logic [LINE_W-1:0] r_l1_rdata;
    logic              r_mem_read;
    logic              r_mem_write;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [LINE_W-1:0] r_mem_wdata;

`ifdef L2_PERF_CNT_EN
    logic [31:0]       r_perf_access;
    logic [31:0]       r_perf_miss;
`endif

    // data array (not reset; only read when the tag RAM says valid)
    logic [LINE_W-1:0] r_data [NUM_OF_SET];

    // request decode: both or neither strobe is not a request
    logic w_rd;
    logic w_wr;
    assign w_rd = bus.l1_read & ~bus.l1_write;
    assign w_wr = bus.l1_write & ~bus.l1_read;

    logic [SET_OFFSET-1:0] w_idx;
    logic [TAG_W-1:0]      w_req_tag;
    assign w_idx     = r_addr[SET_OFFSET-1:0];
    assign w_req_tag = r_addr[ADDR_W-1:SET_OFFSET];

    // lookup of the latched request's set
    logic              w_tag_valid;
    logic              w_tag_dirty;
    logic [TAG_W-1:0]  w_tag;
    logic [LINE_W-1:0] w_line;
    logic              w_hit;
    logic              w_victim_dirty;

    assign w_line         = r_data[w_idx];
    assign w_hit          = w_tag_valid && (w_tag == w_req_tag);
    assign w_victim_dirty = w_tag_valid && w_tag_dirty;

    // array update controls
    logic              w_tr_we;
    logic              w_tr_valid;
    logic              w_tr_dirty;
    logic [TAG_W-1:0]  w_tr_tag;
    logic              w_d_we;
    logic [LINE_W-1:0] w_d_data;

    always_comb begin
        w_tr_we    = 1'b0;
        w_tr_valid = 1'b1;
        w_tr_dirty = 1'b0;
        w_tr_tag   = w_req_tag;
        w_d_we     = 1'b0;
        w_d_data   = r_wdata;
        case (r_state)
            ST_COMPARE: begin
                // a write hit, or a write miss whose victim needs no eviction,
                // installs the full line straight away
                if (r_is_wr && (w_hit || !w_victim_dirty)) begin
                    w_tr_we    = 1'b1;
                    w_tr_dirty = 1'b1;
                    w_d_we     = 1'b1;
                end
            end
            ST_WRITEBACK: begin
                if (bus.mem_ready) begin
                    w_tr_we = 1'b1;
                    if (r_is_wr) begin
                        w_tr_dirty = 1'b1;
                        w_d_we     = 1'b1;
                    end else begin
                        // victim is now clean in memory; keep its tag until
                        // the fetch replaces it
                        w_tr_tag   = w_tag;
                        w_tr_dirty = 1'b0;
                    end
                end
            end
            ST_ALLOCATE: begin
                if (bus.mem_ready) begin
                    w_tr_we  = 1'b1;
                    w_d_we   = 1'b1;
                    w_d_data = bus.mem_rdata;
                end
            end
            default: ;
        endcase
    end

    l2_tag_ram #(
        .NUM_OF_SET (NUM_OF_SET),
        .SET_OFFSET (SET_OFFSET),
        .TAG_W      (TAG_W)
    ) u_tag_ram (
        .clk        (clk),
        .rst_n      (proc_reset_n),
        .i_rd_idx   (w_idx),
        .o_rd_valid (w_tag_valid),
        .o_rd_dirty (w_tag_dirty),
        .o_rd_tag   (w_tag),
        .i_we       (w_tr_we),
        .i_wr_idx   (w_idx),
        .i_wr_valid (w_tr_valid),
        .i_wr_dirty (w_tr_dirty),
        .i_wr_tag   (w_tr_tag)
    );

    always_ff @(posedge clk) begin
        if (w_d_we) begin
            r_data[w_idx] <= w_d_data;
        end
    end

    // controller
    always_ff @(posedge clk or negedge proc_reset_n) begin
        if (!proc_reset_n) begin
            r_state     <= ST_IDLE;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_is_wr     <= 1'b0;
            r_l1_ready  <= 1'b0;
            r_l1_rdata  <= '0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
`ifdef L2_PERF_CNT_EN
            r_perf_access <= '0;
            r_perf_miss   <= '0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_rd || w_wr) begin
                        r_addr  <= bus.l1_addr;
                        r_wdata <= bus.l1_wdata;
                        r_is_wr <= w_wr;
                        r_state <= ST_COMPARE;
                    end
                end
                ST_COMPARE: begin
`ifdef L2_PERF_CNT_EN
                    r_perf_access <= r_perf_access + 32'd1;
                    if (!w_hit) begin
                        r_perf_miss <= r_perf_miss + 32'd1;
                    end
`endif
                    if (w_hit) begin
                        if (!r_is_wr) begin
                            r_l1_rdata <= w_line;
                        end
                        r_l1_ready <= 1'b1;
                        r_state    <= ST_RESPOND;
                    end else if (w_victim_dirty) begin
                        r_mem_write <= 1'b1;
                        r_mem_addr  <= {w_tag, w_idx};
                        r_mem_wdata <= w_line;
                        r_state     <= ST_WRITEBACK;
                    end else if (r_is_wr) begin
                        r_l1_ready <= 1'b1;
                        r_state    <= ST_RESPOND;
                    end else begin
                        r_mem_read <= 1'b1;
                        r_mem_addr <= r_addr;
                        r_state    <= ST_ALLOCATE;
                    end
                end
                ST_WRITEBACK: begin
                    if (bus.mem_ready) begin
                        r_mem_write <= 1'b0;
                        if (r_is_wr) begin
                            r_l1_ready <= 1'b1;
                            r_state    <= ST_RESPOND;
                        end else begin
                            r_mem_read <= 1'b1;
                            r_mem_addr <= r_addr;
                            r_state    <= ST_ALLOCATE;
                        end
                    end
                end
                ST_ALLOCATE: begin
                    if (bus.mem_ready) begin
                        r_mem_read <= 1'b0;
                        r_l1_rdata <= bus.mem_rdata;
                        r_l1_ready <= 1'b1;
                        r_state    <= ST_RESPOND;
                    end
                end
                ST_RESPOND: begin
                    r_l1_ready <= 1'b0;
                    r_state    <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.l1_ready  = r_l1_ready;
    assign bus.l1_rdata  = r_l1_rdata;
    assign bus.mem_read  = r_mem_read;
    assign bus.mem_write = r_mem_write;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign o_dbg_state   = r_state;

`ifdef L2_PERF_CNT_EN
    assign perf_access = r_perf_access;
    assign perf_miss   = r_perf_miss;
`endif

endmodule

// File: tb/tb_l2_cache.sv
`timescale 1ns/1ps
module tb_l2_cache;
    import l2_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic proc_reset_n;
    always #5 clk = ~clk;

    l2_cache_if bus();
    l2_state_e  dbg_state;
`ifdef L2_PERF_CNT_EN
    logic [31:0] perf_access;
    logic [31:0] perf_miss;
`endif

    l2_cache #(
        .NUM_OF_SET (64),
        .SET_OFFSET (6)
    ) dut (
        .clk          (clk),
        .proc_reset_n (proc_reset_n),
        .bus          (bus),
        .o_dbg_state  (dbg_state)
`ifdef L2_PERF_CNT_EN
        ,
        .perf_access  (perf_access),
        .perf_miss    (perf_miss)
`endif
    );

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [159:0] got, input logic [159:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // cache contents as seen by the specification, plus memory image
    bit                m_valid [64];
    bit                m_dirty [64];
    logic [21:0]       m_tag   [64];
    logic [127:0]      m_data  [64];
    logic [127:0]      ref_mem  [logic [27:0]];  // what memory should hold
    logic [127:0]      phys_mem [logic [27:0]];  // what the memory model holds
    int                m_access = 0;
    int                m_miss   = 0;
    // expected memory operations: {is_write, addr, wdata (0 for reads)}
    logic [156:0]      exp_q[$];
    int                mem_lat_min = 1;
    int                mem_lat_max = 4;

    function automatic logic [127:0] mem_init(input logic [27:0] a);
        return {4'hA, a, 4'hB, a, 4'hC, a, 4'hD, a};
    endfunction

    function automatic logic [127:0] ref_rd(input logic [27:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return mem_init(a);
    endfunction

    function automatic logic [127:0] phys_rd(input logic [27:0] a);
        if (phys_mem.exists(a)) return phys_mem[a];
        return mem_init(a);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 64; i++) begin
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
        end
    endtask

    // Predicts one request: expected read data, whether it completes without
    // memory traffic, and the memory operations it must produce.
    task automatic model_req(input bit is_wr, input logic [27:0] a, input logic [127:0] wd,
                             output logic [127:0] exp_rd, output bit fast);
        logic [5:0]  ix;
        logic [21:0] tg;
        ix = a[5:0];
        tg = a[27:6];
        exp_rd = '0;
        fast = 1'b0;
        m_access++;
        if (m_valid[ix] && m_tag[ix] == tg) begin
            fast = 1'b1;
            if (is_wr) begin
                m_data[ix]  = wd;
                m_dirty[ix] = 1'b1;
            end else begin
                exp_rd = m_data[ix];
            end
        end else begin
            m_miss++;
            if (m_valid[ix] && m_dirty[ix]) begin
                exp_q.push_back({1'b1, m_tag[ix], ix, m_data[ix]});
                ref_mem[{m_tag[ix], ix}] = m_data[ix];
            end else begin
                fast = is_wr;
            end
            m_valid[ix] = 1'b1;
            m_tag[ix]   = tg;
            if (is_wr) begin
                m_data[ix]  = wd;
                m_dirty[ix] = 1'b1;
            end else begin
                exp_q.push_back({1'b0, a, 128'h0});
                exp_rd      = ref_rd(a);
                m_data[ix]  = exp_rd;
                m_dirty[ix] = 1'b0;
            end
        end
    endtask

    // ---------------- memory responder ----------------
    initial begin
        logic [156:0] got;
        logic [156:0] e;
        logic [27:0]  a;
        int           lat;
        bus.mem_ready = 1'b0;
        bus.mem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (proc_reset_n && (bus.mem_read || bus.mem_write)) begin
                chk("mem_rd_wr_excl", {bus.mem_read, bus.mem_write}, {bus.mem_read, ~bus.mem_read});
                a   = bus.mem_addr;
                got = {bus.mem_write, bus.mem_addr, bus.mem_write ? bus.mem_wdata : 128'h0};
                chk("mem_op_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("mem_op", got, e);
                end
                lat = $urandom_range(mem_lat_max, mem_lat_min);
                repeat (lat) @(posedge clk);
                #1;
                bus.mem_ready = 1'b1;
                if (got[156]) begin
                    phys_mem[a] = got[127:0];
                    bus.mem_rdata = {$urandom, $urandom, $urandom, $urandom};
                end else begin
                    bus.mem_rdata = phys_rd(a);
                end
                @(posedge clk);
                #1;
                bus.mem_ready = 1'b0;
            end
        end
    end

    // ---------------- driver ----------------
    // Called #1 after a rising edge; returns #1 after a rising edge.
    task automatic do_req(input bit is_wr, input logic [27:0] a, input logic [127:0] wd);
        logic [127:0] exp_rd;
        bit           fast;
        bit           seen;
        int           n;
        model_req(is_wr, a, wd, exp_rd, fast);
        bus.l1_read  = !is_wr;
        bus.l1_write = is_wr;
        bus.l1_addr  = a;
        bus.l1_wdata = wd;
        seen = 1'b0;
        n = 0;
        while (n < 300) begin
            @(posedge clk);
            #1;
            n++;
            if (bus.l1_ready) begin
                seen = 1'b1;
                break;
            end
        end
        bus.l1_read  = 1'b0;
        bus.l1_write = 1'b0;
        chk("l1_ready_seen", seen, 1);
        if (seen && !is_wr) chk("l1_rdata", bus.l1_rdata, exp_rd);
        if (seen && fast) chk("fast_latency", n, 2);
        chk("mem_ops_drained", exp_q.size(), 0);
        @(posedge clk);
        #1;
        chk("l1_ready_one_cycle", bus.l1_ready, 0);
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // ---------------- main sequence ----------------
    localparam logic [127:0] PAT_A = 128'hAAAA_AAAA_AAAA_AAAA_AAAA_AAAA_AAAA_AAAA;
    localparam logic [127:0] PAT_W = 128'h1234_5678_9ABC_DEF0_1234_5678_9ABC_DEF0;

    initial begin
        bit seen;
        proc_reset_n = 1'b0;
        bus.l1_read  = 1'b0;
        bus.l1_write = 1'b0;
        bus.l1_addr  = '0;
        bus.l1_wdata = '0;
        model_reset();
        ref_mem[28'h10]  = PAT_A;
        phys_mem[28'h10] = PAT_A;
        idle_cycles(3);
        chk("rst_l1_ready", bus.l1_ready, 0);
        chk("rst_l1_rdata", bus.l1_rdata, 0);
        chk("rst_mem_read", bus.mem_read, 0);
        chk("rst_mem_write", bus.mem_write, 0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_state", dbg_state, ST_IDLE);
        proc_reset_n = 1'b1;
        idle_cycles(2);

        // cold read, memory answers after 3 cycles; then a hit
        mem_lat_min = 3;
        mem_lat_max = 3;
        do_req(1'b0, 28'h10, '0);
        do_req(1'b0, 28'h10, '0);
        // write hit, read it back
        do_req(1'b1, 28'h10, PAT_W);
        do_req(1'b0, 28'h10, '0);
        // same index, different tag, dirty victim: write-back then fetch
        do_req(1'b0, 28'h50, '0);
`ifdef L2_PERF_CNT_EN
        chk("perf_access", perf_access, m_access);
        chk("perf_miss", perf_miss, m_miss);
`endif
        // write miss on a clean line: no fetch, two-cycle latency
        do_req(1'b1, 28'h90, {4{32'hCAFE_F00D}});

        // both strobes: not a request
        bus.l1_read  = 1'b1;
        bus.l1_write = 1'b1;
        bus.l1_addr  = 28'h90;
        for (int i = 0; i < 4; i++) begin
            idle_cycles(1);
            chk("both_no_ready", bus.l1_ready, 0);
            chk("both_idle", dbg_state, ST_IDLE);
        end
        bus.l1_read  = 1'b0;
        bus.l1_write = 1'b0;
        idle_cycles(1);

        // reset in the middle of a line fetch
        mem_lat_min = 8;
        mem_lat_max = 8;
        exp_q.push_back({1'b0, 28'h21, 128'h0});
        bus.l1_read = 1'b1;
        bus.l1_addr = 28'h21;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            idle_cycles(1);
            if (bus.mem_read) begin
                seen = 1'b1;
                break;
            end
        end
        chk("abort_mem_read_seen", seen, 1);
        #2;
        proc_reset_n = 1'b0;
        bus.l1_read  = 1'b0;
        #1;
        chk("abort_mem_read", bus.mem_read, 0);
        chk("abort_l1_ready", bus.l1_ready, 0);
        chk("abort_state", dbg_state, ST_IDLE);
        model_reset();
        idle_cycles(2);
        #3;
        proc_reset_n = 1'b1;
        idle_cycles(20);
        mem_lat_min = 1;
        mem_lat_max = 4;
        // valid bits were cleared: this read misses again
        do_req(1'b0, 28'h10, '0);

        // randomized traffic over a small address window
        for (int i = 0; i < 150; i++) begin
            logic [27:0] a;
            a = {22'($urandom_range(3, 0)), 6'($urandom_range(3, 0))};
            do_req(1'($urandom_range(1, 0)), a, {$urandom, $urandom, $urandom, $urandom});
            if ($urandom_range(3, 0) == 0) idle_cycles($urandom_range(3, 1));
        end
`ifdef L2_PERF_CNT_EN
        chk("perf_access_end", perf_access, m_access);
        chk("perf_miss_end", perf_miss, m_miss);
`endif
        idle_cycles(10);
        chk("no_stray_mem_ops", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
